// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared widths, FU class enum and FIFO entry type for dispatch_router
package dispatch_pkg;
   localparam int INST_ID_BITS = 6;
   localparam int PRN_BITS     = 6;
   localparam int MAX_OPERANDS = 3;
   localparam int FU_COUNT     = 4;

   // Enum values double as the FU queue index
   typedef enum logic [1:0] {
      FU_LOGICAL = 2'd0,
      FU_ARITH   = 2'd1,
      FU_BRANCH  = 2'd2,
      FU_LDST    = 2'd3
   } fu_class_t;

   typedef struct packed {
      logic [INST_ID_BITS-1:0]                 inst_id;
      logic [31:0]                             raw_instr;
      logic [63:0]                             pc;
      logic [MAX_OPERANDS-1:0]                 prn_input_valid;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn_input;
      logic [MAX_OPERANDS-1:0]                 prn_output_valid;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn_output;
      fu_class_t                               fu;
      logic                                    err;
   } dispatch_entry_t;
endpackage

// File: rtl/dispatch_router_if.sv
// rtl/dispatch_router_if.sv - rename input, FU dispatch bus and writeback broadcast signals
interface dispatch_router_if;
   import dispatch_pkg::*;

   logic                                              in_valid;
   logic                                              in_ready;
   logic [INST_ID_BITS-1:0]                           in_inst_id;
   logic [31:0]                                       in_raw_instr;
   logic [63:0]                                       in_pc;
   logic [MAX_OPERANDS-1:0]                           in_prn_input_valid;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             in_prn_input;
   logic [MAX_OPERANDS-1:0]                           in_prn_output_valid;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             in_prn_output;
   logic [FU_COUNT-1:0]                               fu_inst_valid;
   logic [FU_COUNT-1:0]                               fu_queue_ready;
   logic [INST_ID_BITS-1:0]                           inst_id;
   logic [31:0]                                       raw_instr;
   logic [63:0]                                       instr_pc;
   logic [MAX_OPERANDS-1:0]                           prn_input_valid;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             prn_input;
   logic [MAX_OPERANDS-1:0]                           prn_output_valid;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             prn_output;
   logic [MAX_OPERANDS-1:0]                           prn_input_ready;
   logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]             wb_set_prn_ready;
   logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wb_set_prn;
   logic                                              decode_err;

   modport master (
      input  in_valid, in_inst_id, in_raw_instr, in_pc, in_prn_input_valid, in_prn_input,
             in_prn_output_valid, in_prn_output, fu_queue_ready, wb_set_prn_ready, wb_set_prn,
      output in_ready, fu_inst_valid, inst_id, raw_instr, instr_pc, prn_input_valid, prn_input,
             prn_output_valid, prn_output, prn_input_ready, decode_err
   );

   modport slave (
      output in_valid, in_inst_id, in_raw_instr, in_pc, in_prn_input_valid, in_prn_input,
             in_prn_output_valid, in_prn_output, fu_queue_ready, wb_set_prn_ready, wb_set_prn,
      input  in_ready, fu_inst_valid, inst_id, raw_instr, instr_pc, prn_input_valid, prn_input,
             prn_output_valid, prn_output, prn_input_ready, decode_err
   );
endinterface

// File: rtl/dispatch_router_fu_class_decode.sv
// rtl/dispatch_router_fu_class_decode.sv - AArch64 op0 based FU classification
module fu_class_decode
   import dispatch_pkg::*;
(
   input  logic [31:0] raw_instr,
   output fu_class_t   fu,
   output logic        err
);
   logic [3:0] op0;
   assign op0 = raw_instr[28:25];

   // Unrecognised groups fall back to the arith queue with err raised
   always_comb begin
      fu  = FU_ARITH;
      err = 1'b0;
      if (op0[3:1] == 3'b100)
         fu = (raw_instr[25:23] == 3'b100) ? FU_LOGICAL : FU_ARITH;
      else if (op0[2:0] == 3'b101)
         fu = (raw_instr[28:24] == 5'b01010) ? FU_LOGICAL : FU_ARITH;
      else if (op0[3:1] == 3'b101)
         fu = FU_BRANCH;
      else if (op0[2] && !op0[0])
         fu = FU_LDST;
      else
         err = 1'b1;
   end
endmodule

// File: rtl/dispatch_router.sv
// rtl/dispatch_router.sv - in-order dispatch FIFO, FU routing and PRN ready scoreboard (option: DISPATCH_STATS_EN)
module dispatch_router
   import dispatch_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   dispatch_router_if.master  bus
`ifdef DISPATCH_STATS_EN
   ,
   output logic [FU_COUNT-1:0][31:0] stall_cycles,
   output logic [31:0]               dispatched_count
`endif
);
   localparam int PTR_BITS = $clog2(BUF_DEPTH);
   localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(BUF_DEPTH);

   dispatch_entry_t               fifo [BUF_DEPTH];
   dispatch_entry_t               in_entry;
   dispatch_entry_t               head;
   logic [PTR_BITS-1:0]           wr_ptr;
   logic [PTR_BITS-1:0]           rd_ptr;
   logic [PTR_BITS:0]             count;
   logic [2**PRN_BITS-1:0]        sb;
   fu_class_t                     in_fu;
   logic                          in_err;
   logic                          head_valid;
   logic                          push;
   logic                          pop;
   logic [FU_COUNT-1:0]           fu_valid;
   logic [MAX_OPERANDS-1:0]       hit;

   fu_class_decode u_decode (
      .raw_instr (bus.in_raw_instr),
      .fu        (in_fu),
      .err       (in_err)
   );

   assign bus.in_ready = (count != FULL_COUNT);
   assign head_valid   = (count != '0);
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = |(fu_valid & bus.fu_queue_ready);

   always_comb begin
      in_entry                  = '0;
      in_entry.inst_id          = bus.in_inst_id;
      in_entry.raw_instr        = bus.in_raw_instr;
      in_entry.pc               = bus.in_pc;
      in_entry.prn_input_valid  = bus.in_prn_input_valid;
      in_entry.prn_input        = bus.in_prn_input;
      in_entry.prn_output_valid = bus.in_prn_output_valid;
      in_entry.prn_output       = bus.in_prn_output;
      in_entry.fu               = in_fu;
      in_entry.err              = in_err;
   end

   // Bus reads as all-zero when nothing is queued
   always_comb begin
      head = '0;
      if (head_valid)
         head = fifo[rd_ptr];
   end

   always_comb begin
      fu_valid = '0;
      for (int k = 0; k < FU_COUNT; k++)
         fu_valid[k] = head_valid && (int'(head.fu) == k);
   end

   assign bus.fu_inst_valid    = fu_valid;
   assign bus.inst_id          = head.inst_id;
   assign bus.raw_instr        = head.raw_instr;
   assign bus.instr_pc         = head.pc;
   assign bus.prn_input_valid  = head.prn_input_valid;
   assign bus.prn_input        = head.prn_input;
   assign bus.prn_output_valid = head.prn_output_valid;
   assign bus.prn_output       = head.prn_output;
   assign bus.decode_err       = pop && head.err;

   // Same-cycle writeback bypass on top of the registered scoreboard
   always_comb begin
      hit = '0;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
         hit[i] = sb[head.prn_input[i]];
         for (int f = 0; f < FU_COUNT; f++)
            for (int j = 0; j < MAX_OPERANDS; j++)
               if (bus.wb_set_prn_ready[f][j] && (bus.wb_set_prn[f][j] == head.prn_input[i]))
                  hit[i] = 1'b1;
      end
   end

   assign bus.prn_input_ready = hit & head.prn_input_valid;

   always_ff @(posedge clk) begin
      if (push)
         fifo[wr_ptr] <= in_entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         count <= count + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop);
      end
   end

   // Clears are applied after sets so a same-edge collision leaves the PRN busy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb <= '1;
      end else begin
         for (int f = 0; f < FU_COUNT; f++)
            for (int j = 0; j < MAX_OPERANDS; j++)
               if (bus.wb_set_prn_ready[f][j])
                  sb[bus.wb_set_prn[f][j]] <= 1'b1;
         if (pop)
            for (int i = 0; i < MAX_OPERANDS; i++)
               if (head.prn_output_valid[i])
                  sb[head.prn_output[i]] <= 1'b0;
      end
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles     <= '0;
         dispatched_count <= '0;
      end else begin
         for (int k = 0; k < FU_COUNT; k++)
            if (fu_valid[k] && !bus.fu_queue_ready[k] && (stall_cycles[k] != '1))
               stall_cycles[k] <= stall_cycles[k] + 32'd1;
         if (pop && (dispatched_count != '1))
            dispatched_count <= dispatched_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dispatch_router.sv
// tb/tb_dispatch_router.sv - directed and randomized checks of dispatch_router against a queue model
module tb_dispatch_router;
   import dispatch_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dispatch_router_if ifc ();

`ifdef DISPATCH_STATS_EN
   logic [FU_COUNT-1:0][31:0] stall_cycles;
   logic [31:0]               dispatched_count;
`endif

   dispatch_router #(.BUF_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
`ifdef DISPATCH_STATS_EN
      ,
      .stall_cycles     (stall_cycles),
      .dispatched_count (dispatched_count)
`endif
   );

   typedef struct {
      logic [5:0]       id;
      logic [31:0]      raw;
      logic [63:0]      pc;
      logic [2:0]       iv;
      logic [2:0][5:0]  ip;
      logic [2:0]       ov;
      logic [2:0][5:0]  op;
      int               fu;
      bit               err;
   } ent_t;

   ent_t mq[$];
   bit   sb_m[64];
   int   stall_m[4];
   int   disp_m;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int model_fu(input logic [31:0] r, output bit err);
      logic [3:0] op0;
      op0 = r[28:25];
      err = 1'b0;
      casez (op0)
         4'b100?: return (r[25:23] == 3'b100) ? 0 : 1;
         4'b?101: return (r[28:24] == 5'b01010) ? 0 : 1;
         4'b101?: return 2;
         4'b?1?0: return 3;
         default: begin err = 1'b1; return 1; end
      endcase
   endfunction

   // Check the DUT against the model, then advance the model to the coming edge
   always @(negedge clk) begin
      ent_t       h;
      ent_t       n;
      bit         ne, xfer, acc, byp;
      logic [3:0] ev;
      logic [2:0] er;
      if (!rst) begin
         mq.delete();
         foreach (sb_m[p]) sb_m[p] = 1'b1;
         foreach (stall_m[k]) stall_m[k] = 0;
         disp_m = 0;
         chk("rst_fu_valid", ifc.fu_inst_valid, 0);
         chk("rst_in_ready", ifc.in_ready, 1);
         chk("rst_decode_err", ifc.decode_err, 0);
         chk("rst_bus_raw", ifc.raw_instr, 0);
      end else begin
         ne = (mq.size() != 0);
         h = '{default: 0};
         if (ne) h = mq[0];
         ev = ne ? 4'(1 << h.fu) : 4'b0;
         er = '0;
         for (int i = 0; i < 3; i++) begin
            byp = sb_m[int'(h.ip[i])];
            for (int f = 0; f < 4; f++)
               for (int j = 0; j < 3; j++)
                  if (ifc.wb_set_prn_ready[f][j] && ifc.wb_set_prn[f][j] == h.ip[i]) byp = 1'b1;
            er[i] = h.iv[i] && byp;
         end
         xfer = ne && ifc.fu_queue_ready[h.fu];
         acc  = ifc.in_valid && (mq.size() < DEPTH);
         chk("fu_inst_valid", ifc.fu_inst_valid, ev);
         chk("in_ready", ifc.in_ready, (mq.size() < DEPTH));
         chk("inst_id", ifc.inst_id, h.id);
         chk("raw_instr", ifc.raw_instr, h.raw);
         chk("instr_pc", ifc.instr_pc, h.pc);
         chk("prn_in", {ifc.prn_input_valid, ifc.prn_input}, {h.iv, h.ip});
         chk("prn_out", {ifc.prn_output_valid, ifc.prn_output}, {h.ov, h.op});
         chk("prn_input_ready", ifc.prn_input_ready, er);
         chk("decode_err", ifc.decode_err, xfer && h.err);
`ifdef DISPATCH_STATS_EN
         for (int k = 0; k < 4; k++) chk("stall_cycles", stall_cycles[k], stall_m[k]);
         chk("dispatched_count", dispatched_count, disp_m);
`endif
         for (int k = 0; k < 4; k++)
            if (ev[k] && !ifc.fu_queue_ready[k]) stall_m[k]++;
         if (xfer) disp_m++;
         for (int f = 0; f < 4; f++)
            for (int j = 0; j < 3; j++)
               if (ifc.wb_set_prn_ready[f][j]) sb_m[int'(ifc.wb_set_prn[f][j])] = 1'b1;
         if (xfer) begin
            for (int i = 0; i < 3; i++)
               if (h.ov[i]) sb_m[int'(h.op[i])] = 1'b0;
            void'(mq.pop_front());
         end
         if (acc) begin
            n.id = ifc.in_inst_id;  n.raw = ifc.in_raw_instr;  n.pc = ifc.in_pc;
            n.iv = ifc.in_prn_input_valid;  n.ip = ifc.in_prn_input;
            n.ov = ifc.in_prn_output_valid; n.op = ifc.in_prn_output;
            n.fu = model_fu(ifc.in_raw_instr, n.err);
            mq.push_back(n);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input bit v, input logic [5:0] id, input logic [31:0] raw,
                           input logic [2:0] iv, input logic [17:0] ip,
                           input logic [2:0] ov, input logic [17:0] op);
      ifc.in_valid            = v;
      ifc.in_inst_id          = id;
      ifc.in_raw_instr        = raw;
      ifc.in_pc               = 64'h4000 + 64'(id) * 4;
      ifc.in_prn_input_valid  = iv;
      ifc.in_prn_input        = ip;
      ifc.in_prn_output_valid = ov;
      ifc.in_prn_output       = op;
   endtask

   task automatic clear_wb();
      ifc.wb_set_prn_ready = '0;
      ifc.wb_set_prn       = '0;
   endtask

   initial begin
      drive_in(0, 0, 0, 0, 0, 0, 0);
      ifc.fu_queue_ready = '0;
      clear_wb();
      @(negedge clk);
      chk("init_in_ready", ifc.in_ready, 1);
      chk("init_fu_valid", ifc.fu_inst_valid, 0);
      tick();
      rst = 1'b1;

      // AND immediate goes to the logical queue and leaves in one cycle
      ifc.fu_queue_ready = 4'b1111;
      drive_in(1, 6'd1, 32'h9240_0000, 0, 0, 0, 0);
      tick();
      ifc.in_valid = 0;
      @(negedge clk);
      chk("and_imm_valid", ifc.fu_inst_valid, 4'b0001);
      chk("and_imm_err", ifc.decode_err, 0);
      tick();
      @(negedge clk);
      chk("and_imm_popped", ifc.fu_inst_valid, 0);

      // ADD register stalled five cycles on the arith queue
      ifc.fu_queue_ready = 4'b1101;
      drive_in(1, 6'd2, 32'h8B02_0020, 3'b011, {6'd0, 6'd2, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd3});
      tick();
      ifc.in_valid = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("add_stall_valid", ifc.fu_inst_valid, 4'b0010);
         chk("add_bus_stable", ifc.raw_instr, 32'h8B02_0020);
         tick();
      end
      ifc.fu_queue_ready = 4'b1111;
      @(negedge clk);
      chk("add_xfer_valid", ifc.fu_inst_valid, 4'b0010);
      chk("add_src_ready", ifc.prn_input_ready, 3'b011);
`ifdef DISPATCH_STATS_EN
      chk("add_stall_cycles", stall_cycles[1], 5);
`endif
      tick();
      @(negedge clk);
      chk("add_done", ifc.fu_inst_valid, 0);

      // Fill the FIFO behind a stalled head
      ifc.fu_queue_ready = 4'b0000;
      drive_in(1, 6'd10, 32'h8B02_0020, 0, 0, 0, 0);
      tick();
      drive_in(1, 6'd11, 32'h1400_0000, 0, 0, 0, 0);
      tick();
      drive_in(1, 6'd12, 32'h9240_0000, 0, 0, 0, 0);
      @(negedge clk);
      chk("full_in_ready", ifc.in_ready, 0);
      chk("full_head_id", ifc.inst_id, 10);
      tick();
      ifc.in_valid = 0;
      ifc.fu_queue_ready = 4'b1111;
      @(negedge clk);
      chk("full_pop_in_ready", ifc.in_ready, 0);
      chk("full_pop_head", ifc.fu_inst_valid, 4'b0010);
      tick();
      @(negedge clk);
      chk("full_second_id", ifc.inst_id, 11);
      chk("full_second_fu", ifc.fu_inst_valid, 4'b0100);
      chk("full_in_ready_back", ifc.in_ready, 1);
      tick();
      @(negedge clk);
      chk("full_drained", ifc.fu_inst_valid, 0);

      // PRN 9 produced by one dispatch and consumed by the next
      drive_in(1, 6'd20, 32'h8B02_0020, 0, 0, 3'b001, {6'd0, 6'd0, 6'd9});
      tick();
      drive_in(1, 6'd21, 32'h8B02_0020, 3'b001, {6'd0, 6'd0, 6'd9}, 0, 0);
      tick();
      ifc.in_valid = 0;
      ifc.fu_queue_ready = 4'b0000;
      @(negedge clk);
      chk("sb_busy_9", ifc.prn_input_ready, 3'b000);
      tick();
      ifc.wb_set_prn_ready[2][1] = 1'b1;
      ifc.wb_set_prn[2][1] = 6'd9;
      ifc.fu_queue_ready = 4'b1111;
      @(negedge clk);
      chk("bypass_9", ifc.prn_input_ready, 3'b001);
      tick();
      clear_wb();

      // Clear and set of PRN 12 on the same edge
      drive_in(1, 6'd30, 32'h8B02_0020, 0, 0, 3'b001, {6'd0, 6'd0, 6'd12});
      tick();
      ifc.in_valid = 0;
      ifc.wb_set_prn_ready[0][0] = 1'b1;
      ifc.wb_set_prn[0][0] = 6'd12;
      @(negedge clk);
      chk("clash_xfer", ifc.fu_inst_valid, 4'b0010);
      tick();
      clear_wb();
      ifc.fu_queue_ready = 4'b0000;
      drive_in(1, 6'd31, 32'h8B02_0020, 3'b001, {6'd0, 6'd0, 6'd12}, 0, 0);
      tick();
      ifc.in_valid = 0;
      @(negedge clk);
      chk("clear_wins_12", ifc.prn_input_ready, 3'b000);
      tick();
      ifc.fu_queue_ready = 4'b1111;
      tick();

      // Unclassified encoding flags decode_err only while transferring
      ifc.fu_queue_ready = 4'b0000;
      drive_in(1, 6'd40, 32'h0000_0000, 0, 0, 0, 0);
      tick();
      ifc.in_valid = 0;
      @(negedge clk);
      chk("err_route", ifc.fu_inst_valid, 4'b0010);
      chk("err_wait", ifc.decode_err, 0);
      tick();
      ifc.fu_queue_ready = 4'b1111;
      @(negedge clk);
      chk("err_xfer", ifc.decode_err, 1);
      tick();
      @(negedge clk);
      chk("err_after", ifc.decode_err, 0);

      // Reset with two entries queued
      ifc.fu_queue_ready = 4'b0000;
      drive_in(1, 6'd41, 32'h1400_0000, 0, 0, 0, 0);
      tick();
      drive_in(1, 6'd42, 32'h9240_0000, 0, 0, 0, 0);
      tick();
      ifc.in_valid = 0;
      @(negedge clk);
      chk("pre_rst_full", ifc.in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", ifc.in_ready, 1);
      chk("mid_rst_valid", ifc.fu_inst_valid, 0);
      tick();
      rst = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
         end
         drive_in($urandom_range(0, 9) < 7, 6'($urandom), $urandom, 3'($urandom),
                  {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))},
                  3'($urandom),
                  {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))});
         for (int k = 0; k < 4; k++) ifc.fu_queue_ready[k] = ($urandom_range(0, 9) < 6);
         for (int f = 0; f < 4; f++)
            for (int j = 0; j < 3; j++) begin
               ifc.wb_set_prn_ready[f][j] = ($urandom_range(0, 9) < 1);
               ifc.wb_set_prn[f][j] = 6'($urandom_range(0, 15));
            end
         tick();
      end

      ifc.in_valid = 0;
      ifc.fu_queue_ready = 4'b1111;
      clear_wb();
      repeat (5) tick();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
